am_search: RTL
==============

AM_SEARCH -- requirements
Module: am_search

Interface
REQ-001 DIM, 1024: hypervector width in bits.
REQ-002 CLS_NUM, 10: number of class rows in the associative memory (AM).
REQ-003 CLS_DW, 4: class index width, equal to $clog2(CLS_NUM).
REQ-004 SEG_W, 64: segment width compared per cycle; DIM SHALL be a multiple of SEG_W, NSEG = DIM/SEG_W.
REQ-005 DIST_W, 11: distance width, equal to $clog2(DIM+1).
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 wr_en  in  1  write a trained class hypervector into the AM.
REQ-009 wr_cls  in  CLS_DW  class index for write.
REQ-010 wr_hv  in  DIM  trained class hypervector.
REQ-011 wr_ready  out  1  write accepted this cycle.
REQ-012 q_valid  in  1  query hypervector valid.
REQ-013 q_hv  in  DIM  encoded query hypervector.
REQ-014 q_ready  out  1  query accepted when q_valid & q_ready.
REQ-015 res_valid  out  1  classification result valid.
REQ-016 res_ready  in  1  consumer accepts result.
REQ-017 res_cls  out  CLS_DW  nearest class index.
REQ-018 res_dist  out  DIST_W  Hamming distance to the nearest class.
REQ-019 busy  out  1  high in CALC or DONE.

Function
REQ-020 The FSM SHALL have three states: IDLE, CALC and DONE; IDLE -> CALC on query accept; CALC -> DONE after the last segment of class CLS_NUM-1; DONE -> IDLE on res_valid & res_ready.
REQ-021 wr_ready and q_ready SHALL equal (state==IDLE).
REQ-022 A write with wr_en & wr_ready & wr_cls<CLS_NUM SHALL store wr_hv in AM[wr_cls] and set cls_vld[wr_cls].
REQ-023 A write with wr_cls>=CLS_NUM, or a write issued when wr_ready=0, SHALL be ignored with no state change.
REQ-024 On query accept, q_hv SHALL be latched, the class index, segment index and accumulator SHALL be cleared, and best_dist SHALL be set to all-ones.
REQ-025 Each CALC cycle SHALL add popcount(q_seg XOR AM[cls][seg]) to the accumulator, with segment 0 = bits [SEG_W-1:0].
REQ-026 After the last segment of a class, if cls_vld[cls] is set and the total distance < best_dist (strictly less), best_dist and best_cls SHALL be updated; on ties the lower index is kept.
REQ-027 Invalid classes SHALL still consume NSEG cycles, so latency is fixed.
REQ-028 res_valid SHALL rise exactly CLS_NUM*NSEG+1 cycles after the accept edge.
REQ-029 While res_valid is high, res_valid, res_cls and res_dist SHALL be held stable until res_ready is asserted.
REQ-030 If no class is valid, the result SHALL be res_cls=0 and res_dist=all-ones.
REQ-031 When a write and a query are accepted on the same IDLE edge, the search SHALL use the newly written row.
REQ-032 The accumulator SHALL not overflow, since the maximum distance is DIM < 2^DIST_W.

Reset
REQ-033 On rst: state=IDLE, res_valid=0, res_cls=0, res_dist=0, busy=0, cls_vld=0, and counters and accumulator cleared.
REQ-034 Reset asserted mid-search SHALL drop the query; no result SHALL be produced for it.
REQ-035 The AM data array SHALL not be reset; cls_vld alone marks valid content.

Structure
REQ-036 DIM, CLS_NUM, CLS_DW, SEG_W, DIST_W and the state enum SHALL live in shared package hdc_pkg.
REQ-037 The per-segment bit count SHALL use one instance of the existing popcount sub-module with DW=SEG_W.
REQ-038 The AM SHALL be an inferred CLS_NUM x DIM register array with a combinational segment read mux.

Verification (DIM=1024, SEG_W=64, CLS_NUM=10; latency 161)
REQ-039 Write class 3 = all-ones and class 7 = all-zeros, then query all-zeros -> res_cls=7, res_dist=0, res_valid at accept+161.
REQ-040 Classes 2 and 5 both at distance 100 from the query -> res_cls=2, res_dist=100 (tie keeps the lower index).
REQ-041 No writes, then a query -> res_cls=0, res_dist=2047; a write with wr_cls=12 is ignored.
REQ-042 Hold res_ready=0 for 20 cycles -> result stable, q_ready=0 and a concurrent write is ignored; on release, q_ready=1 the next cycle.
REQ-043 Assert rst at accept+50 -> res_valid stays 0, cls_vld is cleared, and a new query then returns res_dist=2047.
REQ-044 Write class 4 on the same edge as query accept with q_hv equal to the written data -> res_cls=4, res_dist=0.

Source files
------------

// File: rtl/hdc_pkg.sv
// rtl/hdc_pkg.sv - shared constants and FSM state type for the HDC associative-memory search
//
// Purpose : hypervector geometry, class/distance widths and the search FSM
//           state enum, shared by am_search and its popcount helper.
// Ports   : none (package).

package hdc_pkg;

  localparam int DIM     = 1024;               // hypervector width
  localparam int CLS_NUM = 10;                 // class rows in the AM
  localparam int CLS_DW  = 4;                  // $clog2(CLS_NUM)
  localparam int SEG_W   = 64;                 // bits compared per cycle
  localparam int NSEG    = DIM / SEG_W;        // segments per class row
  localparam int SEG_IW  = $clog2(NSEG);       // segment index width
  localparam int DIST_W  = 11;                 // $clog2(DIM+1)
  localparam int POP_W   = $clog2(SEG_W + 1);  // per-segment popcount width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/am_search_popcount.sv
// rtl/am_search_popcount.sv - combinational population count of a DW-bit word
//
// Purpose : counts the set bits of i_data.
// Ports   : i_data  [DW-1:0] word to count
//           o_count [CW-1:0] number of ones in i_data

module am_search_popcount #(
  parameter int DW = 64,
  parameter int CW = $clog2(DW + 1)
) (
  input  logic [DW-1:0] i_data,
  output logic [CW-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < DW; i++) begin
      o_count = o_count + CW'(i_data[i]);
    end
  end

endmodule

// File: rtl/am_search.sv
// rtl/am_search.sv - nearest-class Hamming search over a hypervector associative memory
//
// Purpose : stores up to CLS_NUM trained class hypervectors and, for each
//           accepted query, walks every class one SEG_W-bit segment per cycle,
//           returning the valid class with the smallest Hamming distance.
// Ports   : clk, rst                 clock, synchronous active-high reset
//           wr_en/wr_cls/wr_hv       class write, accepted when wr_ready
//           wr_ready                 high in IDLE
//           q_valid/q_hv/q_ready     query handshake, q_ready high in IDLE
//           res_valid/res_ready      result handshake
//           res_cls/res_dist         nearest class and its distance
//           busy                     high while searching or holding a result

module am_search
  import hdc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CLS_DW-1:0] wr_cls,
  input  logic [DIM-1:0]    wr_hv,
  output logic              wr_ready,
  input  logic              q_valid,
  input  logic [DIM-1:0]    q_hv,
  output logic              q_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CLS_DW-1:0] res_cls,
  output logic [DIST_W-1:0] res_dist,
  output logic              busy
);

  localparam logic [CLS_DW-1:0] CLS_LAST = CLS_DW'(CLS_NUM - 1);
  localparam logic [SEG_IW-1:0] SEG_LAST = SEG_IW'(NSEG - 1);

  state_t                       r_state;
  logic [CLS_NUM-1:0]           r_cls_vld;
  logic [NSEG-1:0][SEG_W-1:0]   r_am [CLS_NUM];
  logic [NSEG-1:0][SEG_W-1:0]   r_q;
  logic [CLS_DW-1:0]            r_cls;
  logic [SEG_IW-1:0]            r_seg;
  logic [DIST_W-1:0]            r_acc;
  logic [DIST_W-1:0]            r_best_dist;
  logic [CLS_DW-1:0]            r_best_cls;
  logic                         r_res_valid;
  logic [CLS_DW-1:0]            r_res_cls;
  logic [DIST_W-1:0]            r_res_dist;

  logic                         w_idle;
  logic                         w_wr_fire;
  logic [SEG_W-1:0]             w_q_seg;
  logic [SEG_W-1:0]             w_am_seg;
  logic [SEG_W-1:0]             w_xor;
  logic [POP_W-1:0]             w_pop;
  logic [DIST_W-1:0]            w_total;
  logic                         w_last_seg;

  assign w_idle    = (r_state == IDLE);
  assign w_wr_fire = wr_en && w_idle && (wr_cls <= CLS_LAST);

  assign wr_ready  = w_idle;
  assign q_ready   = w_idle;
  assign busy      = !w_idle;
  assign res_valid = r_res_valid;
  assign res_cls   = r_res_cls;
  assign res_dist  = r_res_dist;

  // Segment read mux: segment 0 is the least significant SEG_W bits.
  assign w_q_seg    = r_q[r_seg];
  assign w_am_seg   = r_am[r_cls][r_seg];
  assign w_xor      = w_q_seg ^ w_am_seg;
  assign w_total    = r_acc + DIST_W'(w_pop);
  assign w_last_seg = (r_seg == SEG_LAST);

  am_search_popcount #(
    .DW (SEG_W),
    .CW (POP_W)
  ) u_popcount (
    .i_data  (w_xor),
    .o_count (w_pop)
  );

  // AM rows carry no reset; r_cls_vld alone says which rows hold content.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_am[wr_cls] <= wr_hv;
    end
  end

  always_ff @(posedge clk) begin
    if (w_idle && q_valid) begin
      r_q <= q_hv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cls_vld   <= '0;
      r_cls       <= '0;
      r_seg       <= '0;
      r_acc       <= '0;
      r_best_dist <= '0;
      r_best_cls  <= '0;
      r_res_valid <= 1'b0;
      r_res_cls   <= '0;
      r_res_dist  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_wr_fire) begin
            r_cls_vld[wr_cls] <= 1'b1;
          end
          if (q_valid) begin
            r_state     <= CALC;
            r_cls       <= '0;
            r_seg       <= '0;
            r_acc       <= '0;
            r_best_dist <= '1;
            r_best_cls  <= '0;
          end
        end
        CALC: begin
          if (w_last_seg) begin
            r_acc <= '0;
            r_seg <= '0;
            // Strict less-than keeps the lower class index on ties.
            if (r_cls_vld[r_cls] && (w_total < r_best_dist)) begin
              r_best_dist <= w_total;
              r_best_cls  <= r_cls;
            end
            if (r_cls == CLS_LAST) begin
              r_state <= DONE;
            end else begin
              r_cls <= r_cls + 1'b1;
            end
          end else begin
            r_acc <= w_total;
            r_seg <= r_seg + 1'b1;
          end
        end
        DONE: begin
          // First DONE cycle publishes the winner; afterwards hold until taken.
          if (!r_res_valid) begin
            r_res_valid <= 1'b1;
            r_res_cls   <= r_best_cls;
            r_res_dist  <= r_best_dist;
          end else if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
